add_reservation_station: RTL and testbench

- Reservation station for the add/subtract functional unit in the Tomasulo core.
- Sits between the issue stage and the add/sub ALU state controller.
- Accepts issued instructions, snoops the CDB to capture pending operands, and dispatches ready entries to the ALU when the ALU reports it is available.
- Each entry's tag names the result the ALU later broadcasts; an entry is freed when its own tag appears on the CDB.

---
 rtl/add_reservation_station.sv | 179 +++++++++++++++++
 tb/tb_add_reservation_station.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_reservation_station.sv
// Reservation station for the add/sub unit: holds issued ops, snoops the CDB, dispatches ready ops.
// Latency: an op issued with resolved operands can dispatch the cycle after issue; aluEN is combinational.
// Backpressure: issueAvailable low stalls the issue stage; aluAvailable low holds Ready entries in place.
module add_reservation_station #(
  parameter int ENTRIES  = 3,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 1,
  parameter int OP_W     = 2
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             issueEN,
  input  logic [OP_W-1:0]  issueOp,
  input  logic [TAG_W-1:0] issueQj,
  input  logic [31:0]      issueVj,
  input  logic [TAG_W-1:0] issueQk,
  input  logic [31:0]      issueVk,
  output logic             issueAvailable,
  output logic [TAG_W-1:0] issueTag,
  input  logic             cdbValid,
  input  logic [TAG_W-1:0] cdbTag,
  input  logic [31:0]      cdbData,
  input  logic             aluAvailable,
  output logic             aluEN,
  output logic [OP_W-1:0]  aluOp,
  output logic [31:0]      aluData1,
  output logic [31:0]      aluData2,
  output logic [TAG_W-1:0] aluTag
);

  localparam logic [1:0] ST_EMPTY     = 2'd0;
  localparam logic [1:0] ST_WAITING   = 2'd1;
  localparam logic [1:0] ST_READY     = 2'd2;
  localparam logic [1:0] ST_EXECUTING = 2'd3;

  logic [1:0]       state [ENTRIES];
  logic [OP_W-1:0]  opR   [ENTRIES];
  logic [TAG_W-1:0] qj    [ENTRIES];
  logic [TAG_W-1:0] qk    [ENTRIES];
  logic [31:0]      vj    [ENTRIES];
  logic [31:0]      vk    [ENTRIES];

  logic [ENTRIES-1:0] issueSel;
  logic [ENTRIES-1:0] dispSel;
  logic [ENTRIES-1:0] hitJ;
  logic [ENTRIES-1:0] hitK;
  logic               anyReady;
  logic               doIssue;

  logic [TAG_W-1:0] issQj;
  logic [TAG_W-1:0] issQk;
  logic [31:0]      issVj;
  logic [31:0]      issVk;

  // Entry i is permanently bound to tag TAG_BASE+i; the ALU result comes back under that tag.
  function automatic logic [TAG_W-1:0] entryTag(input int idx);
    return TAG_W'(TAG_BASE + idx);
  endfunction

  // Pick the lowest-index Empty entry as the issue target; tag 0 when the station is full.
  always_comb begin
    issueSel       = '0;
    issueAvailable = 1'b0;
    issueTag       = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!issueAvailable && state[i] == ST_EMPTY) begin
        issueSel[i]    = 1'b1;
        issueAvailable = 1'b1;
        issueTag       = entryTag(i);
      end
    end
  end

  assign doIssue = issueEN & issueAvailable;

  // Same-cycle forwarding: a broadcast coinciding with issue is captured so the wakeup is not lost.
  always_comb begin
    issQj = issueQj;
    issVj = issueVj;
    issQk = issueQk;
    issVk = issueVk;
    if (cdbValid && issueQj != '0 && issueQj == cdbTag) begin
      issQj = '0;
      issVj = cdbData;
    end
    if (cdbValid && issueQk != '0 && issueQk == cdbTag) begin
      issQk = '0;
      issVk = cdbData;
    end
  end

  // CDB snoop matches for Waiting entries, per operand.
  always_comb begin
    hitJ = '0;
    hitK = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hitJ[i] = cdbValid && state[i] == ST_WAITING && qj[i] != '0 && qj[i] == cdbTag;
      hitK[i] = cdbValid && state[i] == ST_WAITING && qk[i] != '0 && qk[i] == cdbTag;
    end
  end

  // Dispatch the lowest-index Ready entry from pre-edge state; outputs are zero when nothing goes out.
  always_comb begin
    dispSel  = '0;
    anyReady = 1'b0;
    aluOp    = '0;
    aluData1 = '0;
    aluData2 = '0;
    aluTag   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!anyReady && state[i] == ST_READY) begin
        anyReady = 1'b1;
        if (aluAvailable) begin
          dispSel[i] = 1'b1;
          aluOp      = opR[i];
          aluData1   = vj[i];
          aluData2   = vk[i];
          aluTag     = entryTag(i);
        end
      end
    end
  end

  assign aluEN = aluAvailable & anyReady;

  // Per-entry lifecycle: Empty -> Waiting/Ready -> Executing -> Empty on own-tag broadcast.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state[i] <= ST_EMPTY;
        opR[i]   <= '0;
        qj[i]    <= '0;
        qk[i]    <= '0;
        vj[i]    <= '0;
        vk[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        case (state[i])
          ST_EMPTY: begin
            if (doIssue && issueSel[i]) begin
              opR[i]   <= issueOp;
              qj[i]    <= issQj;
              vj[i]    <= issVj;
              qk[i]    <= issQk;
              vk[i]    <= issVk;
              state[i] <= (issQj == '0 && issQk == '0) ? ST_READY : ST_WAITING;
            end
          end
          ST_WAITING: begin
            if (hitJ[i]) begin
              qj[i] <= '0;
              vj[i] <= cdbData;
            end
            if (hitK[i]) begin
              qk[i] <= '0;
              vk[i] <= cdbData;
            end
            // Both operands may resolve in the same cycle (or one was already resolved).
            if ((hitJ[i] || qj[i] == '0) && (hitK[i] || qk[i] == '0)) begin
              state[i] <= ST_READY;
            end
          end
          ST_READY: begin
            if (dispSel[i]) begin
              state[i] <= ST_EXECUTING;
            end
          end
          ST_EXECUTING: begin
            if (cdbValid && cdbTag == entryTag(i)) begin
              state[i] <= ST_EMPTY;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_add_reservation_station.sv
// Bench for add_reservation_station: vector table plus hand-written multi-cycle sequences.
// Dispatches are checked by a negedge monitor against a queue of expected dispatches.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_add_reservation_station;

  logic        clk = 1'b0;
  logic        nRST;
  logic        issueEN;
  logic [1:0]  issueOp;
  logic [3:0]  issueQj;
  logic [31:0] issueVj;
  logic [3:0]  issueQk;
  logic [31:0] issueVk;
  logic        issueAvailable;
  logic [3:0]  issueTag;
  logic        cdbValid;
  logic [3:0]  cdbTag;
  logic [31:0] cdbData;
  logic        aluAvailable;
  logic        aluEN;
  logic [1:0]  aluOp;
  logic [31:0] aluData1;
  logic [31:0] aluData2;
  logic [3:0]  aluTag;

  always #5 clk = ~clk;

  add_reservation_station dut (
    .clk(clk), .nRST(nRST),
    .issueEN(issueEN), .issueOp(issueOp), .issueQj(issueQj), .issueVj(issueVj),
    .issueQk(issueQk), .issueVk(issueVk),
    .issueAvailable(issueAvailable), .issueTag(issueTag),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
    .aluAvailable(aluAvailable), .aluEN(aluEN), .aluOp(aluOp),
    .aluData1(aluData1), .aluData2(aluData2), .aluTag(aluTag)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  tag;
  } disp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  qj;
    logic [31:0] vj;
    logic [3:0]  qk;
    logic [31:0] vk;
    logic        cdbV;
    logic [3:0]  cdbT;
    logic [31:0] cdbD;
    logic [31:0] expD1;
    logic [31:0] expD2;
  } vec_t;

  localparam int NV = 5;
  vec_t  vecs [NV];
  disp_t expQ [$];
  disp_t monE;
  int    checks = 0;
  int    errors = 0;
  bit    monOn  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectDisp(input logic [1:0] op, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [3:0] tag);
    disp_t e;
    e.op = op; e.d1 = d1; e.d2 = d2; e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic idleIn();
    issueEN = 1'b0; issueOp = '0; issueQj = '0; issueVj = '0; issueQk = '0; issueVk = '0;
    cdbValid = 1'b0; cdbTag = '0; cdbData = '0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] qj, input logic [31:0] vj,
                       input logic [3:0] qk, input logic [31:0] vk);
    issueEN = 1'b1; issueOp = op; issueQj = qj; issueVj = vj; issueQk = qk; issueVk = vk;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    cdbValid = 1'b1; cdbTag = tag; cdbData = data;
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  task automatic toPos();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every dispatch must match the oldest expectation; idle outputs must be zero.
  always @(negedge clk) begin
    if (monOn) begin
      if (aluEN === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dispatch: got tag %0d expected no dispatch", aluTag);
        end else begin
          monE = expQ.pop_front();
          check("disp_op",  {30'b0, aluOp}, {30'b0, monE.op});
          check("disp_d1",  aluData1, monE.d1);
          check("disp_d2",  aluData2, monE.d2);
          check("disp_tag", {28'b0, aluTag}, {28'b0, monE.tag});
        end
      end else begin
        check("idle_outputs", aluData1 | aluData2 | {28'b0, aluTag} | {30'b0, aluOp}, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{op: 2'd0, qj: 4'd0, vj: 32'd5,          qk: 4'd0, vk: 32'd7,
                cdbV: 1'b0, cdbT: 4'd0, cdbD: 32'h0,    expD1: 32'd5,        expD2: 32'd7};
    vecs[1] = '{op: 2'd1, qj: 4'd0, vj: 32'hAAAA_0000, qk: 4'd6, vk: 32'h55,
                cdbV: 1'b1, cdbT: 4'd6, cdbD: 32'd9,    expD1: 32'hAAAA_0000, expD2: 32'd9};
    vecs[2] = '{op: 2'd2, qj: 4'd5, vj: 32'hDEAD,      qk: 4'd0, vk: 32'hFFFF_FFFF,
                cdbV: 1'b1, cdbT: 4'd5, cdbD: 32'h1234, expD1: 32'h1234,     expD2: 32'hFFFF_FFFF};
    vecs[3] = '{op: 2'd3, qj: 4'd4, vj: 32'd1,         qk: 4'd4, vk: 32'd2,
                cdbV: 1'b1, cdbT: 4'd4, cdbD: 32'hCAFE, expD1: 32'hCAFE,     expD2: 32'hCAFE};
    vecs[4] = '{op: 2'd1, qj: 4'd0, vj: 32'h8000_0000, qk: 4'd0, vk: 32'h7FFF_FFFF,
                cdbV: 1'b1, cdbT: 4'd0, cdbD: 32'h99,   expD1: 32'h8000_0000, expD2: 32'h7FFF_FFFF};

    idleIn();
    aluAvailable = 1'b1;
    nRST = 1'b0;
    #3;
    check("rst_issueAvailable", {31'b0, issueAvailable}, 32'd1);
    check("rst_issueTag", {28'b0, issueTag}, 32'd1);
    check("rst_aluEN", {31'b0, aluEN}, 32'd0);
    check("rst_aluData", aluData1 | aluData2 | {28'b0, aluTag}, 32'd0);
    toPos();
    toPos();
    nRST = 1'b1;
    monOn = 1'b1;

    // Table: issue -> dispatch next cycle -> free by own tag.
    for (int n = 0; n < NV; n++) begin
      issue(vecs[n].op, vecs[n].qj, vecs[n].vj, vecs[n].qk, vecs[n].vk);
      if (vecs[n].cdbV) cdb(vecs[n].cdbT, vecs[n].cdbD);
      expectDisp(vecs[n].op, vecs[n].expD1, vecs[n].expD2, 4'd1);
      toNeg();
      check("vec_issueTag", {28'b0, issueTag}, 32'd1);
      check("vec_issueAvail", {31'b0, issueAvailable}, 32'd1);
      check("vec_noEarlyDisp", {31'b0, aluEN}, 32'd0);
      toPos(); idleIn();
      toNeg();
      check("vec_disp", {31'b0, aluEN}, 32'd1);
      toPos(); cdb(4'd1, 32'hBAD0_0000 + n);
      toNeg();
      check("vec_execTag", {28'b0, issueTag}, 32'd2);
      check("vec_execNoDisp", {31'b0, aluEN}, 32'd0);
      toPos(); idleIn();
      toNeg();
      check("vec_freed", {28'b0, issueTag}, 32'd1);
      toPos();
    end

    // Waiting Qj=6 woken two cycles later by a broadcast.
    issue(2'd1, 4'd6, 32'd0, 4'd0, 32'd3);
    expectDisp(2'd1, 32'h10, 32'd3, 4'd1);
    toNeg(); check("wake_issueTag", {28'b0, issueTag}, 32'd1);
    toPos(); idleIn();
    toNeg(); check("wake_wait1", {31'b0, aluEN}, 32'd0);
    toPos(); cdb(4'd6, 32'h10);
    toNeg(); check("wake_wait2", {31'b0, aluEN}, 32'd0);
    check("wake_tag2", {28'b0, issueTag}, 32'd2);
    toPos(); idleIn();
    toNeg(); check("wake_disp", {31'b0, aluEN}, 32'd1);
    toPos(); cdb(4'd1, 32'h0);
    toNeg(); toPos(); idleIn();

    // Fill with Waiting entries; a further issue must be ignored.
    for (int k = 0; k < 3; k++) begin
      issue(2'd2, 4'(7 + k), 32'd0, 4'd0, 32'h100 + k);
      toNeg(); check("fill_issueTag", {28'b0, issueTag}, 32'(k + 1));
      toPos();
    end
    issue(2'd0, 4'd0, 32'h11, 4'd0, 32'h22);
    toNeg();
    check("full_avail", {31'b0, issueAvailable}, 32'd0);
    check("full_tag", {28'b0, issueTag}, 32'd0);
    check("full_noDisp", {31'b0, aluEN}, 32'd0);
    toPos();
    toNeg(); check("full_ignored", {31'b0, aluEN}, 32'd0);
    toPos(); idleIn();
    cdb(4'd7, 32'h70);
    expectDisp(2'd2, 32'h70, 32'h100, 4'd1);
    toNeg(); toPos(); idleIn();
    toNeg(); check("fill_disp0", {31'b0, aluEN}, 32'd1);
    toPos(); cdb(4'd8, 32'h80);
    toNeg(); toPos(); idleIn();
    #1;
    check("pre_rst_aluEN", {31'b0, aluEN}, 32'd1);
    check("pre_rst_tag", {28'b0, aluTag}, 32'd2);
    check("pre_rst_d2", aluData2, 32'h101);
    // Asynchronous reset with entry 0 Executing and entry 1 Ready.
    nRST = 1'b0;
    #1;
    check("midrst_aluEN", {31'b0, aluEN}, 32'd0);
    check("midrst_avail", {31'b0, issueAvailable}, 32'd1);
    check("midrst_tag", {28'b0, issueTag}, 32'd1);
    toNeg(); toPos();
    nRST = 1'b1;
    cdb(4'd1, 32'h5);
    toNeg(); check("postrst_tag1", {28'b0, issueTag}, 32'd1);
    toPos(); cdb(4'd9, 32'h9);
    toNeg(); toPos(); idleIn();
    toNeg();
    check("postrst_noDisp", {31'b0, aluEN}, 32'd0);
    check("postrst_avail", {31'b0, issueAvailable}, 32'd1);
    check("postrst_tag", {28'b0, issueTag}, 32'd1);
    toPos();

    // Tags 1 and 3 Ready, tag 2 Waiting, ALU busy; then lowest-index dispatch order.
    aluAvailable = 1'b0;
    issue(2'd0, 4'd0, 32'hA1, 4'd0, 32'hA2);
    expectDisp(2'd0, 32'hA1, 32'hA2, 4'd1);
    toNeg(); check("prio_tagA", {28'b0, issueTag}, 32'd1);
    toPos(); issue(2'd1, 4'd12, 32'hB1, 4'd0, 32'hB2);
    toNeg(); check("prio_tagB", {28'b0, issueTag}, 32'd2);
    check("prio_busyB", {31'b0, aluEN}, 32'd0);
    toPos(); issue(2'd3, 4'd0, 32'hC1, 4'd0, 32'hC2);
    expectDisp(2'd3, 32'hC1, 32'hC2, 4'd3);
    toNeg(); check("prio_tagC", {28'b0, issueTag}, 32'd3);
    toPos(); idleIn();
    cdb(4'd1, 32'h77);   // own tag of a Ready entry: must not free it
    toNeg(); check("prio_hold1", {31'b0, aluEN}, 32'd0);
    toPos(); idleIn();
    toNeg(); check("prio_hold2", {31'b0, aluEN}, 32'd0);
    check("prio_stillFull", {31'b0, issueAvailable}, 32'd0);
    toPos(); aluAvailable = 1'b1;
    toNeg(); check("prio_first", {28'b0, aluTag}, 32'd1);
    toPos();
    toNeg(); check("prio_second", {28'b0, aluTag}, 32'd3);
    toPos();
    toNeg(); check("prio_noneReady", {31'b0, aluEN}, 32'd0);
    toPos(); cdb(4'd12, 32'hBB);
    expectDisp(2'd1, 32'hBB, 32'hB2, 4'd2);
    toNeg(); toPos(); idleIn();
    toNeg(); check("prio_wakeB", {31'b0, aluEN}, 32'd1);
    toPos(); cdb(4'd3, 32'h0);
    toNeg(); toPos(); idleIn();
    toNeg(); check("free3_tag", {28'b0, issueTag}, 32'd3);
    toPos(); cdb(4'd2, 32'h0);
    toNeg(); toPos(); idleIn();
    toNeg(); check("free2_tag", {28'b0, issueTag}, 32'd2);
    toPos(); cdb(4'd1, 32'h0);
    toNeg(); toPos(); idleIn();
    toNeg(); check("free1_tag", {28'b0, issueTag}, 32'd1);
    check("queue_drained", expQ.size(), 32'd0);
    monOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
